// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Adds a + b + cin LSB-first, one bit per clock, through a single external
// combinational 1-bit full adder (add_x/add_y/add_cin out, add_z/add_cout in).
//
// Handshake: start is sampled on every rising edge while the block is IDLE or
// DONE; a sampled start=1 loads the operands and enters RUN. start is ignored
// during RUN. busy is high for exactly WIDTH cycles; done then pulses for one
// cycle, and sum/cout hold that result until the next operation completes.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             add_x,
    output logic             add_y,
    output logic             add_cin,
    input  logic             add_z,
    input  logic             add_cout,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra counter bit so the count can never wrap inside an operation.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             cout_r;
    logic [CW-1:0]    cnt;

    // Control FSM plus operand/result shift registers, carry and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0
                    // has reached the LSB position.
                    sum_sh <= {add_z, sum_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= add_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_r <= add_cout;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status and full-adder drive decoded from the state register; the adder
    // inputs are held at 0 outside RUN.
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        add_x     = (state == RUN) & a_sh[0];
        add_y     = (state == RUN) & b_sh[0];
        add_cin   = (state == RUN) & carry;
        sum       = sum_sh;
        cout      = cout_r;
        state_dbg = state;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl (WIDTH=8).
// The external full adder is modelled here; expected {cout,sum} values are
// pushed when a start is driven and popped when done is observed.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         add_x;
    logic         add_y;
    logic         add_cin;
    logic         add_z;
    logic         add_cout;
    logic [1:0]   state_dbg;

    logic [W:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    logic prev_done = 1'b0;
    int done_cnt = 0;

    // ---------------- clock / reset / DUT ----------------
    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_cin   (add_cin),
        .add_z     (add_z),
        .add_cout  (add_cout),
        .state_dbg (state_dbg)
    );

    // External 1-bit full adder.
    assign add_z    = add_x ^ add_y ^ add_cin;
    assign add_cout = (add_x & add_y) | (add_x & add_cin) | (add_y & add_cin);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result; done never lasts
    // two cycles in a row.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    check("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
                end
                check("done_width", 32'(prev_done), 32'(0));
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge while the DUT is IDLE or DONE. Returns at the negedge
    // where done is seen, so a following call starts back-to-back.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input bit scramble);
        int  k;
        int  busy_n;
        bit  seen;
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        exp_q.push_back((W+1)'(av) + (W+1)'(bv) + (W+1)'(cv));
        @(negedge clk);
        start  = 1'b0;
        k      = 1;
        busy_n = 0;
        seen   = 0;
        while (!seen && k <= W + 4) begin
            if (busy) busy_n++;
            if (done) begin
                seen = 1;
            end else begin
                if (scramble) begin
                    a   = W'($urandom);
                    b   = W'($urandom);
                    cin = 1'($urandom);
                end
                @(negedge clk);
                k++;
            end
        end
        check("done_seen", 32'(seen), 32'(1));
        check("latency", 32'(k), 32'(W + 1));
        check("busy_cycles", 32'(busy_n), 32'(W));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  d8;
        int  d17;
        int  dwin;
        bit  seen;
        int  k;

        // Reset state, with start high to show it is not taken during reset.
        start = 1'b1;
        a = 8'h55;
        b = 8'h11;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        check("rst_add", 32'({add_x, add_y, add_cin}), 32'(0));
        start = 1'b0;
        rst_n = 1'b1;
        idle_cycles(2);
        check("idle_busy", 32'(busy), 32'(0));

        // Directed operations.
        do_op(8'h00, 8'h00, 1'b0, 0);
        idle_cycles(1);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'hA5, 8'h5A, 1'b1, 0);
        do_op(8'h3C, 8'h0F, 1'b0, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 0);
        idle_cycles(2);

        // start held high for 20 cycles: accepted at edges 0, 9 and 18.
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h030);
        d8 = 0;
        d17 = 0;
        dwin = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                dwin++;
                if (i == 8) d8 = 1;
                if (i == 17) d17 = 1;
            end
        end
        start = 1'b0;
        check("hold_done_e8", 32'(d8), 32'(1));
        check("hold_done_e17", 32'(d17), 32'(1));
        check("hold_done_count", 32'(dwin), 32'(2));
        seen = 0;
        k = 0;
        while (!seen && k < 3 * W) begin
            @(negedge clk);
            k++;
            if (done) seen = 1;
        end
        check("hold_third_done", 32'(seen), 32'(1));
        idle_cycles(2);

        // Reset in the middle of RUN.
        a = 8'h7F;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        exp_q.push_back(9'h080);
        @(negedge clk);
        start = 1'b0;
        idle_cycles(2);
        check("mid_busy_before", 32'(busy), 32'(1));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_sum", 32'(sum), 32'(0));
        check("mid_rst_cout", 32'(cout), 32'(0));
        check("mid_rst_add", 32'({add_x, add_y, add_cin}), 32'(0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        dwin = done_cnt;
        idle_cycles(W + 2);
        check("mid_rst_no_done", 32'(done_cnt - dwin), 32'(0));
        check("mid_rst_idle", 32'(busy), 32'(0));
        do_op(8'h02, 8'h03, 1'b0, 0);
        idle_cycles(1);

        // Operands scrambled during RUN.
        for (int i = 0; i < 4; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1);
        end
        idle_cycles(1);

        // Random operations, mostly back-to-back with occasional gaps.
        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(3);
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge.
REQ-005 a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 cin  input  1  initial carry-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 sum  output  WIDTH  result of a+b+cin, low WIDTH bits.
REQ-011 cout  output  1  final carry-out (bit WIDTH of a+b+cin).
REQ-012 add_x  output  1  operand bit x driven to the external 1-bit full adder.
REQ-013 add_y  output  1  operand bit y driven to the external 1-bit full adder.
REQ-014 add_cin  output  1  carry-in driven to the external 1-bit full adder.
REQ-015 add_z  input  1  sum bit z returned by the external full adder (combinational).
REQ-016 add_cout  input  1  carry-out returned by the external full adder (combinational).

Function
REQ-017 FSM states: IDLE, RUN, DONE; the block shall add LSB-first through the single external full adder, one bit per clock cycle.
REQ-018 IDLE or DONE, start=1 at edge E: latch a, b into shift registers; latch cin into the carry flop; clear the bit counter; go to RUN.
REQ-019 IDLE or DONE, start=0: IDLE stays IDLE; DONE goes to IDLE.
REQ-020 RUN: add_x = A-shift LSB, add_y = B-shift LSB, add_cin = carry flop; in IDLE and DONE all three are 0.
REQ-021 Each RUN edge: shift add_z into the sum shift register from the MSB side; shift A and B right by one; carry <= add_cout; counter increments.
REQ-022 On the RUN edge that processes bit WIDTH-1 (edge E+WIDTH): go to DONE; sum holds all WIDTH bits in order; cout <= add_cout.
REQ-023 Latency: done is high for exactly the one cycle following edge E+WIDTH; busy is high for exactly the WIDTH cycles following edge E.
REQ-024 Arithmetic: {cout,sum} shall equal a + b + cin modulo 2^(WIDTH+1); no overflow flag.
REQ-025 start while in RUN shall be ignored, with no effect on operands, counter or result.
REQ-026 start in the DONE cycle shall be accepted (back-to-back operation); done still pulses for that one cycle.
REQ-027 sum and cout shall hold the last result from DONE until the next completed operation; during RUN the visible sum shall be the partially shifted register and is not valid.
REQ-028 Operand inputs changing during RUN shall not affect the result.
REQ-029 Counter width: ceil(log2(WIDTH))+1 bits; the counter shall not wrap within one operation.

Reset
REQ-030 rst_n=0 shall immediately force: state IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, operand shift registers 0, add_x=add_y=add_cin=0.
REQ-031 Reset mid-RUN shall abandon the operation with no done pulse; the first start after rst_n rises shall begin a fresh operation.
REQ-032 start shall not be accepted on the edge where rst_n is low.

Verification
REQ-033 WIDTH=8, a=0x00, b=0x00, cin=0, start at edge 0 -> busy high for 8 cycles, done pulse after edge 8, sum=0x00, cout=0.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0.
REQ-035 start=1 held high for 20 cycles with a=0x10, b=0x20 -> first op accepted, starts during RUN ignored, second op accepted in the DONE cycle; done pulses after edges 8 and 17, sum=0x30 both times.
REQ-036 a=0x7F, b=0x01 started, rst_n low at cycle 3 -> busy, done, sum, cout, add_* all 0 immediately; no done pulse; a new start of 0x02+0x03 gives sum=0x05 after 8 cycles.
REQ-037 Operands changed every cycle during RUN -> result equals sum of the operands latched at start.
REQ-038 1000 random (a, b, cin) operations, including back-to-back starts -> {cout,sum} matches the a+b+cin reference every time; done is always one cycle wide.
